// File: rtl/nibble_packer.sv
// Packs arrival-ordered 4-bit nibbles into 32-bit words (nibble k at bits [4k+3:4k]).
// Optional partial-word flush and nib_count output when NIBBLE_PACKER_FLUSH_EN is defined.
//
//   state  | meaning
//   S_FILL | collecting nibbles into the buffer, word_valid low
//   S_FULL | holding a completed (or flushed) word, word_valid high
module nibble_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  nib_in,
   input  logic        nib_valid,
   output logic        nib_ready,
   output logic [31:0] word_out,
   output logic        word_valid,
   input  logic        word_ready
`ifdef NIBBLE_PACKER_FLUSH_EN
   ,
   input  logic        flush,
   output logic [3:0]  nib_count
`endif
);

   typedef enum logic {S_FILL, S_FULL} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] word_q, word_d;
   logic [31:0] buf_ins;
   logic        nib_xfer;
   logic        word_xfer;
`ifdef NIBBLE_PACKER_FLUSH_EN
   logic [3:0]  count_q, count_d;
`endif

   assign nib_ready  = (state_q == S_FILL) || word_ready;
   assign nib_xfer   = nib_valid && nib_ready;
   assign word_xfer  = (state_q == S_FULL) && word_ready;
   assign word_valid = (state_q == S_FULL);
   assign word_out   = word_q;
`ifdef NIBBLE_PACKER_FLUSH_EN
   assign nib_count  = count_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      word_d  = word_q;
`ifdef NIBBLE_PACKER_FLUSH_EN
      count_d = count_q;
`endif
      // Unfilled slots are always zero, so the incoming nibble can simply be placed.
      buf_ins = buf_q;
      buf_ins[{cnt_q, 2'b00} +: 4] = nib_in;

      case (state_q)
         S_FILL: begin
            if (nib_xfer && (cnt_q == 3'd7)) begin
               word_d  = buf_ins;
               state_d = S_FULL;
               cnt_d   = 3'd0;
               buf_d   = 32'd0;
`ifdef NIBBLE_PACKER_FLUSH_EN
               count_d = 4'd8;
`endif
            end else begin
               if (nib_xfer) begin
                  buf_d = buf_ins;
                  cnt_d = cnt_q + 3'd1;
               end
`ifdef NIBBLE_PACKER_FLUSH_EN
               if (flush && (nib_xfer || (cnt_q != 3'd0))) begin
                  word_d  = nib_xfer ? buf_ins : buf_q;
                  count_d = {1'b0, cnt_q} + {3'd0, nib_xfer};
                  state_d = S_FULL;
                  cnt_d   = 3'd0;
                  buf_d   = 32'd0;
               end
`endif
            end
         end
         S_FULL: begin
            if (word_xfer) begin
               state_d = S_FILL;
               cnt_d   = 3'd0;
               buf_d   = 32'd0;
               // A nibble arriving with the word handoff starts the next word in slot 0.
               if (nib_xfer) begin
                  buf_d = {28'd0, nib_in};
                  cnt_d = 3'd1;
               end
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FILL;
         cnt_q   <= 3'd0;
         buf_q   <= 32'd0;
         word_q  <= 32'd0;
`ifdef NIBBLE_PACKER_FLUSH_EN
         count_q <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         word_q  <= word_d;
`ifdef NIBBLE_PACKER_FLUSH_EN
         count_q <= count_d;
`endif
      end
   end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer; flush scenarios run when
// NIBBLE_PACKER_FLUSH_EN is defined.
module tb_nibble_packer;

   logic        clk;
   logic        rst_n;
   logic [3:0]  nib_in;
   logic        nib_valid;
   logic        nib_ready;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
`ifdef NIBBLE_PACKER_FLUSH_EN
   logic        flush;
   logic [3:0]  nib_count;
`endif

   int n_vec;
   int n_miss;

   nibble_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nib_in     (nib_in),
      .nib_valid  (nib_valid),
      .nib_ready  (nib_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready)
`ifdef NIBBLE_PACKER_FLUSH_EN
      ,
      .flush      (flush),
      .nib_count  (nib_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      nib_in     = 4'h0;
      nib_valid  = 1'b0;
      word_ready = 1'b0;
`ifdef NIBBLE_PACKER_FLUSH_EN
      flush      = 1'b0;
`endif
      #2;
      n_vec++;
      if (word_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_word_valid got=%b exp=0", word_valid);
      end
      n_vec++;
      if (word_out !== 32'h0) begin
         n_miss++;
         $display("FAIL reset_word_out got=%h exp=00000000", word_out);
      end
`ifdef NIBBLE_PACKER_FLUSH_EN
      n_vec++;
      if (nib_count !== 4'd0) begin
         n_miss++;
         $display("FAIL reset_nib_count got=%0d exp=0", nib_count);
      end
`endif
      #20;
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (nib_ready !== 1'b1) begin
         n_miss++;
         $display("FAIL reset_nib_ready got=%b exp=1", nib_ready);
      end
   endtask

   task automatic test_basic();
      @(posedge clk);
      #1;
      word_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         nib_in    = 4'(i);
         nib_valid = 1'b1;
         step();
         if (i == 7) begin
            n_vec++;
            if (word_valid !== 1'b0) begin
               n_miss++;
               $display("FAIL basic_early_valid got=%b exp=0", word_valid);
            end
         end
      end
      nib_valid = 1'b0;
      n_vec++;
      if (word_valid !== 1'b1 || word_out !== 32'h87654321) begin
         n_miss++;
         $display("FAIL basic_word got valid=%b data=%h exp valid=1 data=87654321", word_valid, word_out);
      end
      step();
      n_vec++;
      if (word_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL basic_one_cycle got=%b exp=0", word_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] vals [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
      word_ready = 1'b0;
      nib_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         nib_in = (i < 8) ? vals[i] : 4'h3;
         step();
         if (i >= 7) begin
            n_vec++;
            if (word_valid !== 1'b1 || word_out !== 32'h0FEDCBA9 || nib_ready !== 1'b0) begin
               n_miss++;
               $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b exp valid=1 data=0fedcba9 ready=0",
                        i, word_valid, word_out, nib_ready);
            end
         end
      end
      nib_in     = 4'h3;
      word_ready = 1'b1;
      #1;
      n_vec++;
      if (nib_ready !== 1'b1) begin
         n_miss++;
         $display("FAIL bp_release_ready got=%b exp=1", nib_ready);
      end
      step();
      n_vec++;
      if (word_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL bp_transfer got valid=%b exp=0", word_valid);
      end
      for (int i = 4; i <= 10; i++) begin
         nib_in = 4'(i);
         step();
      end
      nib_valid = 1'b0;
      n_vec++;
      if (word_valid !== 1'b1 || word_out !== 32'hA9876543) begin
         n_miss++;
         $display("FAIL bp_next_word got valid=%b data=%h exp valid=1 data=a9876543", word_valid, word_out);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3] = '{32'h76543210, 32'hFEDCBA98, 32'h76543210};
      word_ready = 1'b1;
      nib_valid  = 1'b1;
      for (int j = 0; j < 24; j++) begin
         nib_in = 4'(j % 16);
         #1;
         n_vec++;
         if (nib_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_ready[%0d] got=%b exp=1", j, nib_ready);
         end
         step();
         if ((j % 8) == 7) begin
            n_vec++;
            if (word_valid !== 1'b1 || word_out !== exp_w[j / 8]) begin
               n_miss++;
               $display("FAIL b2b_word[%0d] got valid=%b data=%h exp valid=1 data=%h",
                        j / 8, word_valid, word_out, exp_w[j / 8]);
            end
         end else begin
            n_vec++;
            if (word_valid !== 1'b0) begin
               n_miss++;
               $display("FAIL b2b_gap[%0d] got valid=%b exp=0", j, word_valid);
            end
         end
      end
      nib_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_word();
      word_ready = 1'b0;
      nib_valid  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         nib_in = 4'(i);
         step();
      end
      nib_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      n_vec++;
      if (word_out !== 32'h0 || word_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL midreset_async got valid=%b data=%h exp valid=0 data=00000000", word_valid, word_out);
      end
      #1;
      rst_n = 1'b1;
      nib_in    = 4'hA;
      nib_valid = 1'b1;
      word_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 6) begin
            n_vec++;
            if (word_valid !== 1'b0) begin
               n_miss++;
               $display("FAIL midreset_early got valid=%b exp=0", word_valid);
            end
         end
      end
      nib_valid = 1'b0;
      n_vec++;
      if (word_valid !== 1'b1 || word_out !== 32'hAAAAAAAA) begin
         n_miss++;
         $display("FAIL midreset_word got valid=%b data=%h exp valid=1 data=aaaaaaaa", word_valid, word_out);
      end
      step();
   endtask

`ifdef NIBBLE_PACKER_FLUSH_EN
   task automatic test_flush_partial();
      word_ready = 1'b0;
      nib_valid  = 1'b1;
      for (int i = 5; i <= 7; i++) begin
         nib_in = 4'(i);
         step();
      end
      nib_valid = 1'b0;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      n_vec++;
      if (word_valid !== 1'b1 || word_out !== 32'h00000765 || nib_count !== 4'd3) begin
         n_miss++;
         $display("FAIL flush_partial got valid=%b data=%h cnt=%0d exp valid=1 data=00000765 cnt=3",
                  word_valid, word_out, nib_count);
      end
      word_ready = 1'b1;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_vec++;
      if (word_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL flush_empty got valid=%b exp=0", word_valid);
      end
   endtask

   task automatic test_flush_full();
      word_ready = 1'b1;
      nib_valid  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         nib_in = 4'(i);
         flush  = (i == 8);
         step();
      end
      nib_valid = 1'b0;
      n_vec++;
      if (word_valid !== 1'b1 || word_out !== 32'h87654321 || nib_count !== 4'd8) begin
         n_miss++;
         $display("FAIL flush_full got valid=%b data=%h cnt=%0d exp valid=1 data=87654321 cnt=8",
                  word_valid, word_out, nib_count);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         n_vec++;
         if (word_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL flush_no_second[%0d] got valid=%b exp=0", k, word_valid);
         end
      end
      flush = 1'b0;
   endtask
`endif

   initial begin
      n_vec  = 0;
      n_miss = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
`ifdef NIBBLE_PACKER_FLUSH_EN
      test_flush_partial();
      test_flush_full();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
